io_bridge: RTL and testbench
============================

// Module: io_bridge
// PURPOSE
//  Address decoder and MMIO hub on the CPU data bus, directly downstream of the CPU MEM stage.
//  Routes Bus_addr/Bus_wen/Bus_wdata to the DRAM or to on-board peripherals: switches, buttons, LEDs,
//  8-digit 7-seg display and a prescaled timer. Returns Bus_rdata combinationally in the same cycle,
//  because the MEM stage samples it in that cycle.
// PARAMETERS
//  SCAN_DIV    50000        cpu_clk cycles each 7-seg digit is lit (must be >=2)
//  TIMER_RST   32'd0        reset value of the timer count register
//  PRESC_RST   32'd0        reset value of the prescaler reload (0 = tick every cycle)
// PORTS
//  cpu_clk     in   1   system clock, all state rising-edge
//  cpu_rst     in   1   asynchronous, active-low reset
//  Bus_addr    in   32  byte address from CPU MEM stage
//  Bus_wen     in   1   word write strobe, one cycle per store
//  Bus_wdata   in   32  store data
//  Bus_rdata   out  32  load data, combinational
//  dram_addr   out  14  word address = Bus_addr[15:2]
//  dram_wen    out  1   DRAM write enable
//  dram_wdata  out  32  = Bus_wdata
//  dram_rdata  in   32  DRAM async read data
//  sw          in   24  switch levels
//  btn         in   5   button levels
//  led         out  24  LED drive, active-high
//  dig_en      out  8   digit select, active-low
//  dn_seg      out  8   segments {dp,g..a}, active-low
// BEHAVIOUR
//  Map: 0xFFFF_F000 DIG(W) | F020 TCNT(R/W) | F024 TPRESC(R/W) | F060 LED(R/W) | F070 SW(R) | F078 BTN(R).
//  Every other address in 0xFFFF_F000..FFFF_FFFF is unmapped MMIO. All addresses below 0xFFFF_F000 are DRAM.
//  dram_wen = Bus_wen & DRAM hit. Writes to unmapped MMIO and to read-only registers are ignored.
//  Reads return the selected source. Unmapped MMIO and DIG read 0. SW and BTN are zero-extended.
//  LED and DIG registers load Bus_wdata on the clock edge where Bus_wen=1 and the address hits them.
//  Reset: led=0, DIG reg=0, dig_en=8'hFF, dn_seg=8'hFF, TCNT=TIMER_RST, TPRESC=PRESC_RST,
//   scan counter=0, digit index=0, prescale counter=0.
//  7-seg scan:
//   - Counter runs 0..SCAN_DIV-1. On wrap, digit index i advances 0..7 and wraps 7->0.
//   - dig_en is registered: one-hot-low at i.
//   - dn_seg is registered: hex decode of DIG[4i+3:4i], dp always off.
//   - First digit lights one cycle after reset release.
//  Timer:
//   - Prescale counter counts up to TPRESC, then emits a tick and returns to 0.
//   - On a tick, TCNT increments and wraps 0xFFFF_FFFF->0.
//   - A TCNT write in the same cycle as a tick wins: TCNT=Bus_wdata, no increment.
//   - A TPRESC write clears the prescale counter.
//  Reset asserted mid-operation clears all state immediately (async). Nothing is pending across reset.
// CONFIGURATION
//  IO_TIMER_EN:
//   - Defined: timer logic and TCNT/TPRESC registers exist as above.
//   - Undefined: no timer flops; F020/F024 behave as unmapped (read 0, writes ignored).
// STRUCTURE
//  Shared package (defines.vh): MMIO base and per-register address constants, DRAM/MMIO boundary,
//   7-seg hex decode table.
//  One sub-module, seg_scan:
//   - Inputs: cpu_clk, cpu_rst, 32-bit digit word.
//   - Outputs: dig_en, dn_seg.
//   - Contains the scan counter and the decoder.
//  Decode, registers and timer stay in io_bridge.
// TESTING
//  1. Store 0x12345678 to 0x0000_0040 -> dram_wen=1, dram_addr=14'h10, led unchanged.
//     Load from 0x0000_0040 -> Bus_rdata=dram_rdata.
//  2. Store 0x00A5A5A5 to FFFF_F060 -> led=24'hA5A5A5 next cycle.
//     Load from F060 -> 0x00A5A5A5. dram_wen=0.
//  3. sw=24'h00F00F, btn=5'b10001 -> load F070 returns 0x0000F00F; load F078 returns 0x00000011.
//     Load from F100 returns 0.
//  4. SCAN_DIV=4, DIG=0x89ABCDEF -> dig_en steps FE,FD,...,7F every 4 cycles, then wraps to FE.
//     At dig_en=FE, dn_seg = hex pattern of 'F'.
//  5. IO_TIMER_EN defined, TPRESC=2 -> TCNT increments every 3 cycles.
//     TCNT=0xFFFF_FFFF wraps to 0. A TCNT write of 5 coinciding with a tick leaves TCNT=5.
//  6. Assert cpu_rst low mid-scan with led=0xFFFFFF -> led=0, dig_en=FF, dn_seg=FF immediately.
//     Also rerun test 5 with IO_TIMER_EN undefined -> F020 reads 0.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared MMIO map, read-source select codes and 7-segment decode for io_bridge.
// The timer block in io_bridge is built only when IO_TIMER_EN is defined.
package io_bridge_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_DIG    = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TCNT   = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_TPRESC = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN    = 32'hFFFF_F078;

    typedef enum logic [2:0] {
        SEL_DRAM,
        SEL_DIG,
        SEL_TCNT,
        SEL_TPRESC,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_NONE
    } sel_e;

    // Registers decode on the full 32-bit address; anything else at or above MMIO_BASE is a hole.
    function automatic sel_e addr_decode(input logic [31:0] addr);
        sel_e sel;
        if (addr < MMIO_BASE) begin
            sel = SEL_DRAM;
        end else begin
            case (addr)
                ADDR_DIG:    sel = SEL_DIG;
                ADDR_TCNT:   sel = SEL_TCNT;
                ADDR_TPRESC: sel = SEL_TPRESC;
                ADDR_LED:    sel = SEL_LED;
                ADDR_SW:     sel = SEL_SW;
                ADDR_BTN:    sel = SEL_BTN;
                default:     sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    // Active-low {dp,g,f,e,d,c,b,a}; dp held off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] seg;
        case (hex)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_bridge_seg_scan.sv
// Time-multiplexed driver for the 8-digit 7-segment display: each digit is lit for SCAN_DIV
// cycles in turn; dig_en and dn_seg are registered so the first digit appears one cycle after reset.
module seg_scan
    import io_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] digits,
    output logic [7:0]  dig_en,
    output logic [7:0]  dn_seg
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scan_cnt_reg;
    logic [2:0]    idx_reg;
    logic [7:0]    dig_en_reg;
    logic [7:0]    dn_seg_reg;
    logic [3:0]    nib [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
        assign nib[gi] = digits[4*gi +: 4];
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
            dig_en_reg   <= 8'hFF;
            dn_seg_reg   <= 8'hFF;
        end else begin
            if (scan_cnt_reg == SCAN_LAST) begin
                scan_cnt_reg <= '0;
                idx_reg      <= idx_reg + 3'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
            dig_en_reg <= ~(8'b1 << idx_reg);
            dn_seg_reg <= hex_to_seg(nib[idx_reg]);
        end
    end

    assign dig_en = dig_en_reg;
    assign dn_seg = dn_seg_reg;

endmodule

// File: rtl/io_bridge.sv
// CPU data-bus address decoder and MMIO hub: DRAM below 0xFFFF_F000, peripherals above.
// Define IO_TIMER_EN to build the prescaled timer (TCNT/TPRESC); otherwise those addresses are holes.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int          SCAN_DIV  = 50000,
    parameter logic [31:0] TIMER_RST = 32'd0,
    parameter logic [31:0] PRESC_RST = 32'd0
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dn_seg
);

    sel_e        sel;
    logic [23:0] led_reg;
    logic [31:0] dig_reg;
    logic [31:0] tcnt_rdata;
    logic [31:0] tpresc_rdata;

    assign sel        = addr_decode(Bus_addr);
    assign dram_addr  = Bus_addr[15:2];
    assign dram_wdata = Bus_wdata;
    assign dram_wen   = Bus_wen && (sel == SEL_DRAM);

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            led_reg <= '0;
            dig_reg <= '0;
        end else if (Bus_wen) begin
            if (sel == SEL_LED) led_reg <= Bus_wdata[23:0];
            if (sel == SEL_DIG) dig_reg <= Bus_wdata;
        end
    end

    assign led = led_reg;

`ifdef IO_TIMER_EN
    logic [31:0] tcnt_reg;
    logic [31:0] tpresc_reg;
    logic [31:0] pcnt_reg;
    logic        tick;

    assign tick = (pcnt_reg == tpresc_reg);

    // A TCNT store beats a coincident tick; a TPRESC store restarts the prescale period.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            tcnt_reg   <= TIMER_RST;
            tpresc_reg <= PRESC_RST;
            pcnt_reg   <= '0;
        end else begin
            if (Bus_wen && sel == SEL_TPRESC) begin
                tpresc_reg <= Bus_wdata;
                pcnt_reg   <= '0;
            end else if (tick) begin
                pcnt_reg <= '0;
            end else begin
                pcnt_reg <= pcnt_reg + 32'd1;
            end

            if (Bus_wen && sel == SEL_TCNT) begin
                tcnt_reg <= Bus_wdata;
            end else if (tick) begin
                tcnt_reg <= tcnt_reg + 32'd1;
            end
        end
    end

    assign tcnt_rdata   = tcnt_reg;
    assign tpresc_rdata = tpresc_reg;
`else
    logic unused_timer_cfg;

    assign unused_timer_cfg = ^{TIMER_RST, PRESC_RST};
    assign tcnt_rdata       = '0;
    assign tpresc_rdata     = '0;
`endif

    // Same-cycle read path: the MEM stage samples Bus_rdata before the next edge.
    always_comb begin
        Bus_rdata = '0;
        case (sel)
            SEL_DRAM:   Bus_rdata = dram_rdata;
            SEL_TCNT:   Bus_rdata = tcnt_rdata;
            SEL_TPRESC: Bus_rdata = tpresc_rdata;
            SEL_LED:    Bus_rdata = {8'h00, led_reg};
            SEL_SW:     Bus_rdata = {8'h00, sw};
            SEL_BTN:    Bus_rdata = {27'h0, btn};
            default:    Bus_rdata = '0;
        endcase
    end

    seg_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_seg_scan (
        .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst),
        .digits (dig_reg),
        .dig_en (dig_en),
        .dn_seg (dn_seg)
    );

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: constant vector table, hand sequences for scan/timer/reset,
// and randomized bus traffic against a cycle-count based reference model.
module tb_io_bridge;

    localparam int SCAN_DIV = 4;
    localparam logic [31:0] A_DIG = 32'hFFFF_F000, A_TCNT = 32'hFFFF_F020, A_TPRESC = 32'hFFFF_F024;
    localparam logic [31:0] A_LED = 32'hFFFF_F060, A_SW = 32'hFFFF_F070, A_BTN = 32'hFFFF_F078;
    localparam logic [31:0] A_HOLE = 32'hFFFF_F100;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic [31:0] Bus_addr = '0, Bus_wdata = '0, dram_rdata = '0;
    logic        Bus_wen = 1'b0;
    logic [23:0] sw = '0;
    logic [4:0]  btn = '0;
    logic [31:0] Bus_rdata, dram_wdata;
    logic [13:0] dram_addr;
    logic        dram_wen;
    logic [23:0] led;
    logic [7:0]  dig_en, dn_seg;

    always #5 cpu_clk = ~cpu_clk;

    io_bridge #(
        .SCAN_DIV (SCAN_DIV),
        .TIMER_RST(32'd0),
        .PRESC_RST(32'd0)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .Bus_addr  (Bus_addr),
        .Bus_wen   (Bus_wen),
        .Bus_wdata (Bus_wdata),
        .Bus_rdata (Bus_rdata),
        .dram_addr (dram_addr),
        .dram_wen  (dram_wen),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .dig_en    (dig_en),
        .dn_seg    (dn_seg)
    );

    int checks = 0;
    int passed = 0;
    int txn    = 0;

    // Independent 7-seg table: active-low, bit order {dp,g,f,e,d,c,b,a}.
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state; the timer is described by edges elapsed since the last period restart.
    logic [23:0] m_led;
    logic [31:0] m_dig, m_tcnt, m_presc;
    longint      m_clear, n_edge;
    logic [7:0]  exp_en, exp_seg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, txn);
    endtask

    task automatic reset_model();
        m_led = '0; m_dig = '0; m_tcnt = 32'd0; m_presc = 32'd0;
        m_clear = 0; n_edge = 0; exp_en = 8'hFF; exp_seg = 8'hFF;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < 32'hFFFF_F000) return dram_rdata;
        if (a == A_LED) return {8'h0, m_led};
        if (a == A_SW)  return {8'h0, sw};
        if (a == A_BTN) return {27'h0, btn};
`ifdef IO_TIMER_EN
        if (a == A_TCNT)   return m_tcnt;
        if (a == A_TPRESC) return m_presc;
`endif
        return 32'h0;
    endfunction

    task automatic model_edge(input logic [31:0] a, input logic w, input logic [31:0] d);
        int idx;
        n_edge++;
        idx     = int'(((n_edge - 1) / SCAN_DIV) % 8);
        exp_en  = ~(8'b1 << idx);
        exp_seg = seg_tab[m_dig[4*idx +: 4]];
`ifdef IO_TIMER_EN
        begin
            longint p;
            logic   tick;
            p    = longint'(m_presc);
            tick = ((n_edge - 1 - m_clear) % (p + 1)) == p;
            if (w && a == A_TCNT) m_tcnt = d;
            else if (tick) m_tcnt = m_tcnt + 32'd1;
            if (w && a == A_TPRESC) begin
                m_presc = d;
                m_clear = n_edge;
            end
        end
`endif
        if (w && a == A_LED) m_led = d[23:0];
        if (w && a == A_DIG) m_dig = d;
    endtask

    // One bus cycle: combinational outputs sampled at the falling edge, registers 1ns after the rising edge.
    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output logic dw, output logic [13:0] da);
        Bus_addr = a; Bus_wen = w; Bus_wdata = d;
        @(negedge cpu_clk);
        rd = Bus_rdata; dw = dram_wen; da = dram_addr;
        chk("rdata", rd, m_read(a));
        chk("dram_wen", {31'h0, dw}, {31'h0, (w && a < 32'hFFFF_F000)});
        chk("dram_addr", {18'h0, da}, {18'h0, a[15:2]});
        chk("dram_wdata", dram_wdata, d);
        @(posedge cpu_clk);
        model_edge(a, w, d);
        #1;
        chk("led", {8'h0, led}, {8'h0, m_led});
        chk("dig_en", {24'h0, dig_en}, {24'h0, exp_en});
        chk("dn_seg", {24'h0, dn_seg}, {24'h0, exp_seg});
        $display("txn %0d addr=%h wen=%b wdata=%h rdata=%h led=%h dig_en=%h dn_seg=%h",
                 txn, a, w, d, rd, led, dig_en, dn_seg);
        txn++;
        Bus_wen = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_dw;
        logic [13:0] exp_da;
        logic [23:0] exp_led;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic        do_chk;
        logic [31:0] exp_rd;
    } tstep_t;

    vec_t   vecs [12];
    tstep_t tsteps [17];

    initial begin
        logic [31:0] rd;
        logic        dw;
        logic [13:0] da;
        logic        found;

        vecs[0]  = '{32'h0000_0040, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 14'h0010, 24'h000000};
        vecs[1]  = '{32'h0000_0040, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 14'h0010, 24'h000000};
        vecs[2]  = '{A_LED,         1'b1, 32'h00A5_A5A5, 32'h0000_0000, 1'b0, 14'h3C18, 24'hA5A5A5};
        vecs[3]  = '{A_LED,         1'b0, 32'h0000_0000, 32'h00A5_A5A5, 1'b0, 14'h3C18, 24'hA5A5A5};
        vecs[4]  = '{A_SW,          1'b0, 32'h0000_0000, 32'h0000_F00F, 1'b0, 14'h3C1C, 24'hA5A5A5};
        vecs[5]  = '{A_BTN,         1'b0, 32'h0000_0000, 32'h0000_0011, 1'b0, 14'h3C1E, 24'hA5A5A5};
        vecs[6]  = '{A_HOLE,        1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 14'h3C40, 24'hA5A5A5};
        vecs[7]  = '{A_HOLE,        1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 14'h3C40, 24'hA5A5A5};
        vecs[8]  = '{A_SW,          1'b1, 32'h0000_0123, 32'h0000_F00F, 1'b0, 14'h3C1C, 24'hA5A5A5};
        vecs[9]  = '{A_DIG,         1'b1, 32'h89AB_CDEF, 32'h0000_0000, 1'b0, 14'h3C00, 24'hA5A5A5};
        vecs[10] = '{A_DIG,         1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 14'h3C00, 24'hA5A5A5};
        vecs[11] = '{32'hFFFF_EFFC, 1'b1, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b1, 14'h3BFF, 24'hA5A5A5};

        tsteps[0]  = '{A_TPRESC, 1'b1, 32'd2,         1'b0, 32'd0};
        tsteps[1]  = '{A_TCNT,   1'b1, 32'd100,       1'b0, 32'd0};
        tsteps[2]  = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd100};
        tsteps[3]  = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd100};
        tsteps[4]  = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd101};
        tsteps[5]  = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd101};
        tsteps[6]  = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd101};
        tsteps[7]  = '{A_TCNT,   1'b1, 32'hFFFF_FFFF, 1'b1, 32'd102};
        tsteps[8]  = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'hFFFF_FFFF};
        tsteps[9]  = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'hFFFF_FFFF};
        tsteps[10] = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd0};
        tsteps[11] = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd0};
        tsteps[12] = '{A_TCNT,   1'b1, 32'd5,         1'b1, 32'd0};
        tsteps[13] = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd5};
        tsteps[14] = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd5};
        tsteps[15] = '{A_TCNT,   1'b0, 32'd0,         1'b1, 32'd5};
        tsteps[16] = '{A_TPRESC, 1'b0, 32'd0,         1'b1, 32'd2};

        // Reset state while cpu_rst is held low
        sw = 24'h00F00F; btn = 5'b10001; dram_rdata = 32'hDEAD_BEEF;
        reset_model();
        repeat (2) @(posedge cpu_clk);
        Bus_addr = A_TCNT;
        #1;
        chk("rst_led", {8'h0, led}, 32'h0);
        chk("rst_dig_en", {24'h0, dig_en}, 32'hFF);
        chk("rst_dn_seg", {24'h0, dn_seg}, 32'hFF);
        chk("rst_tcnt_rd", Bus_rdata, 32'h0);
        cpu_rst = 1'b1;

        // First digit lights one cycle after release
        bus(A_HOLE, 1'b0, 32'h0, rd, dw, da);
        chk("first_digit", {24'h0, dig_en}, 32'hFE);

        // Constant vector table
        for (int i = 0; i < 12; i++) begin
            bus(vecs[i].addr, vecs[i].wen, vecs[i].wdata, rd, dw, da);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_dram_wen", i), {31'h0, dw}, {31'h0, vecs[i].exp_dw});
            chk($sformatf("vec%0d_dram_addr", i), {18'h0, da}, {18'h0, vecs[i].exp_da});
            chk($sformatf("vec%0d_led", i), {8'h0, led}, {8'h0, vecs[i].exp_led});
        end

        // Asynchronous reset mid-scan clears outputs without waiting for an edge
        bus(A_LED, 1'b1, 32'h00FF_FFFF, rd, dw, da);
        chk("led_full", {8'h0, led}, 32'h00FF_FFFF);
        #2 cpu_rst = 1'b0;
        #1;
        chk("async_led", {8'h0, led}, 32'h0);
        chk("async_dig_en", {24'h0, dig_en}, 32'hFF);
        chk("async_dn_seg", {24'h0, dn_seg}, 32'hFF);
        @(posedge cpu_clk);
        #1 cpu_rst = 1'b1;
        reset_model();

        // Scan: one full lap of 8 digits, then digit 0 shows 'F' from 0x89ABCDEF
        bus(A_DIG, 1'b1, 32'h89AB_CDEF, rd, dw, da);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            bus(A_HOLE, 1'b0, 32'h0, rd, dw, da);
            if (dig_en == 8'hFE && n_edge >= 33) found = 1'b1;
        end
        chk("scan_wrap_found", {31'h0, found}, 32'h1);
        chk("scan_digit0_F", {24'h0, dn_seg}, 32'h8E);

`ifdef IO_TIMER_EN
        for (int i = 0; i < 17; i++) begin
            bus(tsteps[i].addr, tsteps[i].wen, tsteps[i].wdata, rd, dw, da);
            if (tsteps[i].do_chk) chk($sformatf("timer_step%0d", i), rd, tsteps[i].exp_rd);
        end
`else
        bus(A_TCNT, 1'b1, 32'd5, rd, dw, da);
        bus(A_TCNT, 1'b0, 32'd0, rd, dw, da);
        chk("tcnt_unmapped", rd, 32'h0);
        bus(A_TPRESC, 1'b1, 32'd2, rd, dw, da);
        bus(A_TPRESC, 1'b0, 32'd0, rd, dw, da);
        chk("tpresc_unmapped", rd, 32'h0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, d;
            logic        w;
            case ($urandom_range(0, 8))
                0: a = $urandom & 32'h7FFF_FFFC;
                1: a = 32'hFFFF_EFFC;
                2: a = A_DIG;
                3: a = A_TCNT;
                4: a = A_TPRESC;
                5: a = A_LED;
                6: a = A_SW;
                7: a = A_BTN;
                default: a = 32'hFFFF_F000 | (32'($urandom_range(0, 1023)) << 2);
            endcase
            w = ($urandom_range(0, 2) == 0);
            d = $urandom;
            if (a == A_TPRESC) d = 32'($urandom_range(0, 5));
            sw = 24'($urandom);
            btn = 5'($urandom);
            dram_rdata = $urandom;
            bus(a, w, d, rd, dw, da);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
